csr_file: RTL and testbench
===========================

// Module: csr_file
// PURPOSE
//  LoongArch control/status register file; responder for the WB stage's CSR/exception outputs.
//  Serves CSR reads (combinational), CSR masked writes, and exception/ertn commits from WB.
//  Holds CRMD/PRMD/ECFG/ESTAT/ERA/BADV/EENTRY/SAVE0-3/TID/TCFG/TVAL/TICLR and a countdown timer.
//  Drives the interrupt request, exception entry and ertn return address back to the pipeline.
// PARAMETERS
//  COREID  0  reset value of TID
// PORTS
//  clk          in   1   clock
//  resetn       in   1   asynchronous active-low reset
//  csr_re       in   1   WB read request (informational; read path always live)
//  csr_num      in   14  CSR index for read and write
//  csr_rvalue   out  32  read data for csr_num
//  csr_we       in   1   write enable
//  csr_wmask    in   32  per-bit write mask
//  csr_wvalue   in   32  write data
//  wb_ex        in   1   exception commit in WB
//  wb_ecode     in   6   exception code
//  wb_esubcode  in   9   exception subcode
//  wb_pc        in   32  PC of excepting instruction
//  wb_vaddr     in   32  faulting address (ADE=0x08, ALE=0x09)
//  ertn_flush   in   1   ertn commit in WB
//  hw_int_in    in   8   hardware interrupt lines
//  ipi_int_in   in   1   inter-processor interrupt
//  has_int      out  1   pending enabled interrupt
//  ex_entry     out  32  exception entry (EENTRY)
//  ertn_entry   out  32  return address (ERA)
// BEHAVIOUR
//  Map: CRMD 0x00 PRMD 0x01 ECFG 0x04 ESTAT 0x05 ERA 0x06 BADV 0x07 EENTRY 0x0C SAVE0-3 0x30-0x33
//       TID 0x40 TCFG 0x41 TVAL 0x42 (RO) TICLR 0x44 (reads 0); unmapped reads 0, writes ignored.
//  Reset: CRMD={..,DA=1,IE=0,PLV=0}=0x8; TID=COREID; TVAL=0xFFFFFFFF; all other regs/fields 0.
//  Write: field<=(old&~wmask)|(wvalue&wmask), only implemented bits, takes effect next edge.
//   CRMD[3:0], PRMD[2:0], ECFG.LIE[12:11,9:0], ESTAT.IS[1:0] only, EENTRY[31:6], TCFG[31:0].
//  Read: combinational, same cycle; read-after-write in same cycle returns old value.
//  Priority per cycle: wb_ex > ertn_flush > csr_we for CRMD/PRMD/ESTAT.Ecode/ERA/BADV.
//  wb_ex: PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE; CRMD.PLV<=0, IE<=0; ESTAT.Ecode/EsubCode<=inputs;
//   ERA<=wb_pc; BADV<=wb_vaddr iff ecode in {0x08,0x09}.
//  ertn_flush: CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE.
//  ESTAT.IS[9:2]<=hw_int_in, IS[12]<=ipi_int_in every cycle (1-cycle sample latency).
//  Timer: TCFG write with new En=1 -> TVAL<={InitVal[31:2],2'b00}.
//   Else if En & TVAL!=0xFFFFFFFF: TVAL==0 & Periodic -> reload {InitVal,2'b00}; else TVAL-1.
//   One-shot wraps 0->0xFFFFFFFF and stops. En=0 freezes TVAL.
//  IS[11]: set when En & TVAL==0; cleared by TICLR write with wmask[0]&wvalue[0]; clear wins.
//  has_int=CRMD.IE & |(ESTAT.IS[12:0]&ECFG.LIE[12:0]), combinational from registers.
//  ex_entry={EENTRY[31:6],6'b0}; ertn_entry=ERA; both combinational.
//  resetn low at any point: all state returns to reset values immediately, timer stops.
// TESTING
//  Reset, read all mapped CSRs -> CRMD=0x8, TID=COREID, TVAL=0xFFFFFFFF, others 0, 0x99 reads 0.
//  Write SAVE0 wvalue=0xFFFFFFFF wmask=0x0000FF00 over 0x12345678 -> reads 0x1234FF78.
//  CRMD=0x7 then wb_ex ecode=0x09 pc=0x1C000100 vaddr=0x3 -> PRMD=0x7, CRMD.PLV/IE=0,
//   ERA=0x1C000100, BADV=0x3, ESTAT[21:16]=0x09; ertn_flush -> CRMD[2:0]=0x7.
//  TCFG=0x0000000B (InitVal=2,periodic,En) -> TVAL 8,7..0, IS[11]=1, reload 8; TICLR=1 -> IS[11]=0.
//  ECFG.LIE[11]=1, CRMD.IE=1, timer expiry -> has_int=1; IE=0 -> has_int=0.
//  Same cycle wb_ex and csr_we to CRMD=0x3 -> CRMD.PLV=0, IE=0 (exception wins).

Source files
------------

// File: rtl/csr_file.sv
// LoongArch CSR file: masked CSR read/write, exception and ertn commit,
// interrupt pending detection and a countdown timer feeding ESTAT.IS[11].
module csr_file #(
    parameter logic [31:0] COREID = 32'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic        has_int,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry
);

    localparam logic [13:0] A_CRMD   = 14'h00;
    localparam logic [13:0] A_PRMD   = 14'h01;
    localparam logic [13:0] A_ECFG   = 14'h04;
    localparam logic [13:0] A_ESTAT  = 14'h05;
    localparam logic [13:0] A_ERA    = 14'h06;
    localparam logic [13:0] A_BADV   = 14'h07;
    localparam logic [13:0] A_EENTRY = 14'h0C;
    localparam logic [13:0] A_SAVE0  = 14'h30;
    localparam logic [13:0] A_SAVE1  = 14'h31;
    localparam logic [13:0] A_SAVE2  = 14'h32;
    localparam logic [13:0] A_SAVE3  = 14'h33;
    localparam logic [13:0] A_TID    = 14'h40;
    localparam logic [13:0] A_TCFG   = 14'h41;
    localparam logic [13:0] A_TVAL   = 14'h42;
    localparam logic [13:0] A_TICLR  = 14'h44;

    logic [3:0]       crmd_q, crmd_d;
    logic [2:0]       prmd_q, prmd_d;
    logic [12:0]      lie_q, lie_d;
    logic [1:0]       is_sw_q, is_sw_d;
    logic [7:0]       is_hw_q;
    logic             is_ti_q, is_ti_d;
    logic             is_ipi_q;
    logic [5:0]       ecode_q, ecode_d;
    logic [8:0]       esub_q, esub_d;
    logic [31:0]      era_q, era_d;
    logic [31:0]      badv_q, badv_d;
    logic [25:0]      eentry_q, eentry_d;
    logic [3:0][31:0] save_q, save_d;
    logic [31:0]      tid_q, tid_d;
    logic [31:0]      tcfg_q, tcfg_d;
    logic [31:0]      tval_q, tval_d;

    logic [12:0] is_all;
    logic [31:0] wr_new;
    logic        sel_tcfg;
    logic        ex_blk;
    logic        unused_re;

    function automatic logic [31:0] wmerge(input logic [31:0] old_v,
                                           input logic [31:0] wv,
                                           input logic [31:0] wm);
        return (old_v & ~wm) | (wv & wm);
    endfunction

    assign unused_re = csr_re;
    assign is_all    = {is_ipi_q, is_ti_q, 1'b0, is_hw_q, is_sw_q};

    always_comb begin
        case (csr_num)
            A_CRMD:   csr_rvalue = {28'd0, crmd_q};
            A_PRMD:   csr_rvalue = {29'd0, prmd_q};
            A_ECFG:   csr_rvalue = {19'd0, lie_q};
            A_ESTAT:  csr_rvalue = {1'b0, esub_q, ecode_q, 3'b000, is_all};
            A_ERA:    csr_rvalue = era_q;
            A_BADV:   csr_rvalue = badv_q;
            A_EENTRY: csr_rvalue = {eentry_q, 6'd0};
            A_SAVE0:  csr_rvalue = save_q[0];
            A_SAVE1:  csr_rvalue = save_q[1];
            A_SAVE2:  csr_rvalue = save_q[2];
            A_SAVE3:  csr_rvalue = save_q[3];
            A_TID:    csr_rvalue = tid_q;
            A_TCFG:   csr_rvalue = tcfg_q;
            A_TVAL:   csr_rvalue = tval_q;
            default:  csr_rvalue = 32'd0;
        endcase
    end

    assign has_int    = crmd_q[2] & (|(is_all & lie_q));
    assign ex_entry   = {eentry_q, 6'd0};
    assign ertn_entry = era_q;

    // The read mux holds the old value of the addressed CSR, so merging
    // against it gives the post-write image of whichever register is selected.
    assign wr_new   = wmerge(csr_rvalue, csr_wvalue, csr_wmask);
    assign sel_tcfg = csr_we && (csr_num == A_TCFG);
    assign ex_blk   = wb_ex || ertn_flush;

    always_comb begin
        crmd_d   = crmd_q;
        prmd_d   = prmd_q;
        lie_d    = lie_q;
        is_sw_d  = is_sw_q;
        is_ti_d  = is_ti_q;
        ecode_d  = ecode_q;
        esub_d   = esub_q;
        era_d    = era_q;
        badv_d   = badv_q;
        eentry_d = eentry_q;
        save_d   = save_q;
        tid_d    = tid_q;
        tcfg_d   = tcfg_q;
        tval_d   = tval_q;

        if (csr_we) begin
            case (csr_num)
                A_CRMD:   if (!ex_blk) crmd_d = wr_new[3:0];
                A_PRMD:   if (!ex_blk) prmd_d = wr_new[2:0];
                A_ECFG:   lie_d = wr_new[12:0] & 13'h1BFF;
                A_ESTAT:  is_sw_d = wr_new[1:0];
                A_ERA:    if (!ex_blk) era_d = wr_new;
                A_BADV:   if (!ex_blk) badv_d = wr_new;
                A_EENTRY: eentry_d = wr_new[31:6];
                A_SAVE0:  save_d[0] = wr_new;
                A_SAVE1:  save_d[1] = wr_new;
                A_SAVE2:  save_d[2] = wr_new;
                A_SAVE3:  save_d[3] = wr_new;
                A_TID:    tid_d = wr_new;
                A_TCFG:   tcfg_d = wr_new;
                default:  ;
            endcase
        end

        if (wb_ex) begin
            prmd_d  = crmd_q[2:0];
            crmd_d  = {crmd_q[3], 3'b000};
            ecode_d = wb_ecode;
            esub_d  = wb_esubcode;
            era_d   = wb_pc;
            if (wb_ecode == 6'h08 || wb_ecode == 6'h09) badv_d = wb_vaddr;
        end else if (ertn_flush) begin
            crmd_d = {crmd_q[3], prmd_q};
        end

        // A one-shot timer parks at all-ones after passing zero.
        if (sel_tcfg && wr_new[0]) begin
            tval_d = {wr_new[31:2], 2'b00};
        end else if (tcfg_q[0] && tval_q != 32'hFFFF_FFFF) begin
            if (tval_q == 32'd0 && tcfg_q[1]) tval_d = {tcfg_q[31:2], 2'b00};
            else                              tval_d = tval_q - 32'd1;
        end

        if (csr_we && csr_num == A_TICLR && csr_wmask[0] && csr_wvalue[0]) is_ti_d = 1'b0;
        else if (tcfg_q[0] && tval_q == 32'd0)                            is_ti_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd_q   <= 4'h8;
            prmd_q   <= '0;
            lie_q    <= '0;
            is_sw_q  <= '0;
            is_hw_q  <= '0;
            is_ti_q  <= 1'b0;
            is_ipi_q <= 1'b0;
            ecode_q  <= '0;
            esub_q   <= '0;
            era_q    <= '0;
            badv_q   <= '0;
            eentry_q <= '0;
            save_q   <= '0;
            tid_q    <= COREID;
            tcfg_q   <= '0;
            tval_q   <= 32'hFFFF_FFFF;
        end else begin
            crmd_q   <= crmd_d;
            prmd_q   <= prmd_d;
            lie_q    <= lie_d;
            is_sw_q  <= is_sw_d;
            is_hw_q  <= hw_int_in;
            is_ti_q  <= is_ti_d;
            is_ipi_q <= ipi_int_in;
            ecode_q  <= ecode_d;
            esub_q   <= esub_d;
            era_q    <= era_d;
            badv_q   <= badv_d;
            eentry_q <= eentry_d;
            save_q   <= save_d;
            tid_q    <= tid_d;
            tcfg_q   <= tcfg_d;
            tval_q   <= tval_d;
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: directed scenarios plus randomized traffic against a
// register-image reference model.
module tb_csr_file;

    localparam logic [31:0] CID = 32'h0000_0005;

    logic        clk = 1'b0;
    logic        resetn;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;

    always #5 clk = ~clk;

    csr_file #(.COREID(CID)) dut (
        .clk(clk), .resetn(resetn), .csr_re(csr_re), .csr_num(csr_num),
        .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wmask(csr_wmask),
        .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .ertn_flush(ertn_flush), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the readable 32-bit image of every CSR, indexed by address.
    logic [31:0] img [128];
    logic [31:0] nxt [128];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_mapped(input logic [13:0] n);
        case (n)
            14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0C,
            14'h30, 14'h31, 14'h32, 14'h33, 14'h40, 14'h41, 14'h42, 14'h44: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] wr_bits(input logic [13:0] n);
        case (n)
            14'h00:  return 32'h0000_000F;
            14'h01:  return 32'h0000_0007;
            14'h04:  return 32'h0000_1BFF;
            14'h05:  return 32'h0000_0003;
            14'h0C:  return 32'hFFFF_FFC0;
            14'h06, 14'h07, 14'h30, 14'h31, 14'h32, 14'h33, 14'h40, 14'h41: return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mread(input logic [13:0] n);
        if (is_mapped(n)) return img[n[6:0]];
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_has_int();
        logic [31:0] pend;
        pend = img[5] & img[4] & 32'h0000_1FFF;
        return {31'd0, img[0][2] && (pend != 0)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) img[i] = 32'h0;
        img[0]  = 32'h8;
        img[64] = CID;
        img[66] = 32'hFFFF_FFFF;
    endtask

    task automatic model_step();
        logic [31:0] wm, tc_old, tv;
        bit blocked, en;
        int a;
        for (int i = 0; i < 128; i++) nxt[i] = img[i];
        a = int'(csr_num[6:0]);
        blocked = (wb_ex || ertn_flush) &&
                  (csr_num == 14'h00 || csr_num == 14'h01 || csr_num == 14'h06 || csr_num == 14'h07);
        if (csr_we && is_mapped(csr_num) && !blocked) begin
            wm = csr_wmask & wr_bits(csr_num);
            nxt[a] = (img[a] & ~wm) | (csr_wvalue & wm);
        end
        tc_old = img[65];
        en     = tc_old[0];
        tv     = img[66];
        if (csr_we && csr_num == 14'h41 && nxt[65][0]) nxt[66] = nxt[65] & 32'hFFFF_FFFC;
        else if (en && tv != 32'hFFFF_FFFF) begin
            if (tv == 0 && tc_old[1]) nxt[66] = tc_old & 32'hFFFF_FFFC;
            else                      nxt[66] = tv - 1;
        end
        if (csr_we && csr_num == 14'h44 && csr_wmask[0] && csr_wvalue[0]) nxt[5][11] = 1'b0;
        else if (en && tv == 0) nxt[5][11] = 1'b1;
        nxt[5][9:2] = hw_int_in;
        nxt[5][12]  = ipi_int_in;
        if (wb_ex) begin
            nxt[1] = img[0] & 32'h7;
            nxt[0] = img[0] & 32'h8;
            nxt[5][21:16] = wb_ecode;
            nxt[5][30:22] = wb_esubcode;
            nxt[6] = wb_pc;
            if (wb_ecode == 6'h08 || wb_ecode == 6'h09) nxt[7] = wb_vaddr;
        end else if (ertn_flush) begin
            nxt[0] = (img[0] & 32'h8) | (img[1] & 32'h7);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("rdata", csr_rvalue, mread(csr_num));
        chk("has_int", {31'd0, has_int}, exp_has_int());
        chk("ex_entry", ex_entry, img[12]);
        chk("ertn_entry", ertn_entry, img[6]);
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 128; i++) img[i] = nxt[i];
    endtask

    task automatic idle();
        csr_we     = 1'b0;
        csr_wmask  = 32'h0;
        csr_wvalue = 32'h0;
        wb_ex      = 1'b0;
        ertn_flush = 1'b0;
    endtask

    task automatic csrw(input logic [13:0] n, input logic [31:0] v, input logic [31:0] m);
        csr_num = n; csr_we = 1'b1; csr_wvalue = v; csr_wmask = m;
        step();
        idle();
    endtask

    task automatic rdm(input string tag, input logic [13:0] n, input logic [31:0] m, input logic [31:0] exp);
        csr_num = n;
        #1;
        chk(tag, csr_rvalue & m, exp);
    endtask

    logic [13:0] addrs [18] = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0C, 14'h30, 14'h31,
                                14'h32, 14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h02, 14'h99, 14'h1FFF};

    initial begin
        logic [31:0] rexp;
        resetn = 1'b0; csr_re = 1'b1; csr_num = '0; wb_ecode = '0; wb_esubcode = '0;
        wb_pc = '0; wb_vaddr = '0; hw_int_in = '0; ipi_int_in = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 17; i++) begin
            case (addrs[i])
                14'h00:  rexp = 32'h8;
                14'h40:  rexp = CID;
                14'h42:  rexp = 32'hFFFF_FFFF;
                default: rexp = 32'h0;
            endcase
            rdm("reset_rd", addrs[i], 32'hFFFF_FFFF, rexp);
        end
        @(posedge clk);
        #1;
        resetn = 1'b1;

        csrw(14'h30, 32'h1234_5678, 32'hFFFF_FFFF);
        csrw(14'h30, 32'hFFFF_FFFF, 32'h0000_FF00);
        rdm("save0_mask", 14'h30, 32'hFFFF_FFFF, 32'h1234_FF78);

        csrw(14'h00, 32'h7, 32'hF);
        wb_ex = 1'b1; wb_ecode = 6'h09; wb_esubcode = 9'h0; wb_pc = 32'h1C00_0100; wb_vaddr = 32'h3;
        step();
        idle();
        rdm("ex_prmd", 14'h01, 32'hFFFF_FFFF, 32'h7);
        rdm("ex_crmd", 14'h00, 32'h7, 32'h0);
        rdm("ex_era", 14'h06, 32'hFFFF_FFFF, 32'h1C00_0100);
        step();
        rdm("ex_badv", 14'h07, 32'hFFFF_FFFF, 32'h3);
        rdm("ex_ecode", 14'h05, 32'h003F_0000, 32'h0009_0000);
        ertn_flush = 1'b1;
        step();
        idle();
        rdm("ertn_crmd", 14'h00, 32'h7, 32'h7);

        csrw(14'h41, 32'h0000_000B, 32'hFFFF_FFFF);
        rdm("tval_load", 14'h42, 32'hFFFF_FFFF, 32'h8);
        for (int i = 7; i >= 0; i--) begin
            step();
            rdm("tval_cnt", 14'h42, 32'hFFFF_FFFF, i);
        end
        step();
        rdm("tval_reload", 14'h42, 32'hFFFF_FFFF, 32'h8);
        rdm("timer_is", 14'h05, 32'h800, 32'h800);

        csrw(14'h04, 32'h800, 32'hFFFF_FFFF);
        csrw(14'h00, 32'h4, 32'h4);
        #1 chk("has_int_on", {31'd0, has_int}, 32'h1);
        csrw(14'h00, 32'h0, 32'h4);
        #1 chk("has_int_off", {31'd0, has_int}, 32'h0);
        csrw(14'h44, 32'h1, 32'h1);
        rdm("ticlr", 14'h05, 32'h800, 32'h0);
        csrw(14'h41, 32'h0, 32'hFFFF_FFFF);

        csrw(14'h00, 32'h7, 32'hF);
        wb_ex = 1'b1; wb_ecode = 6'h0A; csr_num = 14'h00; csr_we = 1'b1;
        csr_wvalue = 32'h3; csr_wmask = 32'hF;
        step();
        idle();
        rdm("ex_vs_we", 14'h00, 32'h7, 32'h0);

        for (int c = 0; c < 600; c++) begin
            csr_num    = addrs[$urandom_range(0, 17)];
            csr_we     = $urandom_range(0, 1) == 1;
            csr_wvalue = (csr_num == 14'h41) ? 32'($urandom_range(0, 63)) : $urandom;
            csr_wmask  = $urandom;
            case ($urandom_range(0, 9))
                0:       begin wb_ex = 1'b1; ertn_flush = 1'b0; end
                1:       begin wb_ex = 1'b0; ertn_flush = 1'b1; csr_we = 1'b0; end
                default: begin wb_ex = 1'b0; ertn_flush = 1'b0; end
            endcase
            wb_ecode    = ($urandom_range(0, 1) == 1) ? 6'(8 + $urandom_range(0, 1)) : 6'($urandom);
            wb_esubcode = 9'($urandom);
            wb_pc       = $urandom;
            wb_vaddr    = $urandom;
            hw_int_in   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
            ipi_int_in  = $urandom_range(0, 7) == 0;
            step();
        end
        idle();
        hw_int_in = '0; ipi_int_in = 1'b0;

        resetn = 1'b0;
        #1;
        rdm("arst_crmd", 14'h00, 32'hFFFF_FFFF, 32'h8);
        rdm("arst_tval", 14'h42, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rdm("arst_estat", 14'h05, 32'hFFFF_FFFF, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
